// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register indices and address decode.
package gpio_pkg;

    // Register index taken from PADDR[4:2]
    typedef logic [2:0] gpio_idx_t;

    localparam gpio_idx_t GPIO_CR  = 3'd0;
    localparam gpio_idx_t GPIO_IDR = 3'd1;
    localparam gpio_idx_t GPIO_ODR = 3'd2;
    localparam gpio_idx_t GPIO_SET = 3'd3;
    localparam gpio_idx_t GPIO_CLR = 3'd4;
    localparam gpio_idx_t GPIO_RIE = 3'd5;
    localparam gpio_idx_t GPIO_FIE = 3'd6;
    localparam gpio_idx_t GPIO_ISR = 3'd7;

    // Word-aligned register index; the byte-lane bits are ignored
    function automatic gpio_idx_t reg_index(input logic [4:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with one-cycle history for rise/fall detection.
module gpio_sync_edge #(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_PINS-1:0] pad_i,
    output logic [NUM_PINS-1:0] sync_o,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [NUM_PINS-1:0]                  prev_q;

    // Shift pads through the synchroniser chain and remember last synchronised value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO port: direction/output registers with atomic set/clear,
// synchronised inputs, per-pin edge interrupts with W1C status.
module apb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [4:0]          PADDR,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                irq,
    inout  wire  [NUM_PINS-1:0] gpio
);

    logic [NUM_PINS-1:0] cr_q,  cr_d;
    logic [NUM_PINS-1:0] odr_q, odr_d;
    logic [NUM_PINS-1:0] rie_q, rie_d;
    logic [NUM_PINS-1:0] fie_q, fie_d;
    logic [NUM_PINS-1:0] isr_q, isr_d;
    logic [31:0]         prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                irq_q, irq_d;

    logic [NUM_PINS-1:0] sync_s, rise_s, fall_s;
    logic [NUM_PINS-1:0] wdata_s, rdata_s, w1c_s;
    logic                access_s, rd_en_s, wr_en_s;
    gpio_idx_t           idx_s;

    // Byte-lane address bits and unimplemented data bits carry no meaning
    logic unused_addr_s;
    assign unused_addr_s = ^PADDR[1:0];

    if (NUM_PINS < 32) begin : g_unused_hi
        logic unused_hi_s;
        assign unused_hi_s = ^PWDATA[31:NUM_PINS];
    end

    gpio_sync_edge #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .pad_i  (gpio),
        .sync_o (sync_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    assign access_s = PSEL & PENABLE;
    // Read data is captured as PREADY rises; writes commit as the PREADY cycle ends
    assign rd_en_s  = access_s & ~PWRITE & ~pready_q;
    assign wr_en_s  = access_s & PWRITE & pready_q;
    assign idx_s    = reg_index(PADDR);
    assign wdata_s  = PWDATA[NUM_PINS-1:0];

    // Read multiplexer; write-only and unknown registers read as zero
    always_comb begin
        rdata_s = '0;
        case (idx_s)
            GPIO_CR:  rdata_s = cr_q;
            GPIO_IDR: rdata_s = sync_s;
            GPIO_ODR: rdata_s = odr_q;
            GPIO_SET: rdata_s = '0;
            GPIO_CLR: rdata_s = '0;
            GPIO_RIE: rdata_s = rie_q;
            GPIO_FIE: rdata_s = fie_q;
            GPIO_ISR: rdata_s = isr_q;
            default:  rdata_s = '0;
        endcase
    end

    // Handshake, read capture, register writes and interrupt status next-state
    always_comb begin
        pready_d = access_s & ~pready_q;
        prdata_d = prdata_q;
        cr_d     = cr_q;
        odr_d    = odr_q;
        rie_d    = rie_q;
        fie_d    = fie_q;
        w1c_s    = '0;

        if (rd_en_s) begin
            prdata_d = 32'(rdata_s);
        end else begin
            prdata_d = prdata_q;
        end

        if (wr_en_s) begin
            case (idx_s)
                GPIO_CR:  cr_d  = wdata_s;
                GPIO_ODR: odr_d = wdata_s;
                GPIO_SET: odr_d = odr_q | wdata_s;
                GPIO_CLR: odr_d = odr_q & ~wdata_s;
                GPIO_RIE: rie_d = wdata_s;
                GPIO_FIE: fie_d = wdata_s;
                GPIO_ISR: w1c_s = wdata_s;
                default:  w1c_s = '0;   // IDR is read-only
            endcase
        end else begin
            w1c_s = '0;
        end

        // A fresh edge event wins over a simultaneous clear of the same bit
        isr_d = (isr_q & ~w1c_s) | (rise_s & rie_q) | (fall_s & fie_q);
        irq_d = |isr_q;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cr_q     <= '0;
            odr_q    <= '0;
            rie_q    <= '0;
            fie_q    <= '0;
            isr_q    <= '0;
            prdata_q <= 32'd0;
            pready_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cr_q     <= cr_d;
            odr_q    <= odr_d;
            rie_q    <= rie_d;
            fie_q    <= fie_d;
            isr_q    <= isr_d;
            prdata_q <= prdata_d;
            pready_q <= pready_d;
            irq_q    <= irq_d;
        end
    end

    assign PRDATA = prdata_q;
    assign PREADY = pready_q;
    assign irq    = irq_q;

    // Per-pin tristate: drive only pins configured as outputs
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pad
        assign gpio[i] = cr_q[i] ? odr_q[i] : 1'bz;
    end

endmodule
